// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back scheduler.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    GNT_LSU = 1'b0,
    GNT_ALU = 1'b1
  } grant_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: tracks busy registers, raises WAW stall
// and reports whether each source operand is still pending.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_rd,
  input  logic [REG_AW-1:0]   wr_addr,
  input  logic [REG_AW-1:0]   rs1_addr,
  input  logic [REG_AW-1:0]   rs2_addr,
  output logic                iss_stall,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                dispatch;

  always_comb begin
    iss_stall = 1'b0;
    rs1_busy  = 1'b0;
    rs2_busy  = 1'b0;
    dispatch  = 1'b0;
    if (!Reset) begin
      iss_stall = iss_valid && busy_q[iss_rd];
      rs1_busy  = busy_q[rs1_addr] && (rs1_addr != REG_ZERO);
      rs2_busy  = busy_q[rs2_addr] && (rs2_addr != REG_ZERO);
      dispatch  = iss_valid && !iss_stall && (iss_rd != REG_ZERO);
    end

    // Clear first so a same-edge dispatch to the same register wins.
    busy_d = busy_q;
    if (wr_addr != REG_ZERO) busy_d[wr_addr] = 1'b0;
    if (dispatch) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Round-robin write-back arbiter for the register file write port plus hazard
// scoreboard. Define RF_WB_BYPASS_EN to forward the in-flight write to reads.
module rf_wb_scheduler
  import rf_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Iss_Valid,
  input  logic [REG_AW-1:0]   Iss_Rd,
  output logic                Iss_Stall,
  input  logic                Alu_Valid,
  output logic                Alu_Ready,
  input  logic [REG_AW-1:0]   Alu_Rd,
  input  logic [XLEN-1:0]     Alu_Data,
  input  logic                Lsu_Valid,
  output logic                Lsu_Ready,
  input  logic [REG_AW-1:0]   Lsu_Rd,
  input  logic [XLEN-1:0]     Lsu_Data,
  output logic [REG_AW-1:0]   Rd_Addr,
  output logic [XLEN-1:0]     Rd_Data,
  input  logic [REG_AW-1:0]   Rs1_Addr,
  input  logic [REG_AW-1:0]   Rs2_Addr,
  output logic                Rs1_Busy,
  output logic                Rs2_Busy,
  input  logic [XLEN-1:0]     Rs1_Rf_Data,
  input  logic [XLEN-1:0]     Rs2_Rf_Data,
  output logic [XLEN-1:0]     Rs1_Data,
  output logic [XLEN-1:0]     Rs2_Data,
  output logic [NUM_REGS-1:0] Busy_Vec
);

  grant_e            ptr_q, ptr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              sb_rs1_busy, sb_rs2_busy;
  logic              rs1_hit, rs2_hit;

  rf_scoreboard u_scoreboard (
    .Clk       (Clk),
    .Reset     (Reset),
    .iss_valid (Iss_Valid),
    .iss_rd    (Iss_Rd),
    .wr_addr   (rd_addr_q),
    .rs1_addr  (Rs1_Addr),
    .rs2_addr  (Rs2_Addr),
    .iss_stall (Iss_Stall),
    .rs1_busy  (sb_rs1_busy),
    .rs2_busy  (sb_rs2_busy),
    .busy_vec  (Busy_Vec)
  );

  // The pointer only moves on contention; a lone requester leaves it alone.
  always_comb begin
    Alu_Ready = 1'b0;
    Lsu_Ready = 1'b0;
    ptr_d     = ptr_q;
    rd_addr_d = REG_ZERO;
    rd_data_d = rd_data_q;
    if (!Reset) begin
      Alu_Ready = Alu_Valid && (!Lsu_Valid || (ptr_q == GNT_ALU));
      Lsu_Ready = Lsu_Valid && (!Alu_Valid || (ptr_q == GNT_LSU));
      if (Alu_Valid && Lsu_Valid)
        ptr_d = (ptr_q == GNT_ALU) ? GNT_LSU : GNT_ALU;
      if (Alu_Ready) begin
        rd_addr_d = Alu_Rd;
        rd_data_d = Alu_Data;
      end else if (Lsu_Ready) begin
        rd_addr_d = Lsu_Rd;
        rd_data_d = Lsu_Data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q     <= GNT_LSU;
      rd_addr_q <= REG_ZERO;
      rd_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign rs1_hit = (Rs1_Addr == rd_addr_q) && (rd_addr_q != REG_ZERO);
  assign rs2_hit = (Rs2_Addr == rd_addr_q) && (rd_addr_q != REG_ZERO);
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  always_comb begin
    Rs1_Data = '0;
    Rs2_Data = '0;
    Rs1_Busy = 1'b0;
    Rs2_Busy = 1'b0;
    if (!Reset) begin
      Rs1_Data = rs1_hit ? rd_data_q : Rs1_Rf_Data;
      Rs2_Data = rs2_hit ? rd_data_q : Rs2_Rf_Data;
      Rs1_Busy = sb_rs1_busy && !rs1_hit;
      Rs2_Busy = sb_rs2_busy && !rs2_hit;
    end
  end

  assign Rd_Addr = rd_addr_q;
  assign Rd_Data = rd_data_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized self-checking bench for rf_wb_scheduler with a behavioural model
// of the scoreboard, round-robin write port and an attached register file.
module tb_rf_wb_scheduler;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic        Iss_Valid;
  logic [4:0]  Iss_Rd;
  logic        Iss_Stall;
  logic        Alu_Valid, Alu_Ready;
  logic [4:0]  Alu_Rd;
  logic [31:0] Alu_Data;
  logic        Lsu_Valid, Lsu_Ready;
  logic [4:0]  Lsu_Rd;
  logic [31:0] Lsu_Data;
  logic [4:0]  Rd_Addr;
  logic [31:0] Rd_Data;
  logic [4:0]  Rs1_Addr, Rs2_Addr;
  logic        Rs1_Busy, Rs2_Busy;
  logic [31:0] Rs1_Rf_Data, Rs2_Rf_Data;
  logic [31:0] Rs1_Data, Rs2_Data;
  logic [31:0] Busy_Vec;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model state: busy bits, pending write port contents, round-robin owner.
  logic [31:0] m_busy = '0;
  logic [4:0]  m_rd_addr = '0;
  logic [31:0] m_rd_data = '0;
  bit          m_ptr_alu = 1'b0;
  logic [31:0] rf [32];
  bit          alu_done = 1'b0;
  bit          lsu_done = 1'b0;

  assign Rs1_Rf_Data = rf[Rs1_Addr];
  assign Rs2_Rf_Data = rf[Rs2_Addr];

  rf_wb_scheduler dut (
    .Clk(Clk), .Reset(Reset),
    .Iss_Valid(Iss_Valid), .Iss_Rd(Iss_Rd), .Iss_Stall(Iss_Stall),
    .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Rd(Alu_Rd), .Alu_Data(Alu_Data),
    .Lsu_Valid(Lsu_Valid), .Lsu_Ready(Lsu_Ready), .Lsu_Rd(Lsu_Rd), .Lsu_Data(Lsu_Data),
    .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
    .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr),
    .Rs1_Busy(Rs1_Busy), .Rs2_Busy(Rs2_Busy),
    .Rs1_Rf_Data(Rs1_Rf_Data), .Rs2_Rf_Data(Rs2_Rf_Data),
    .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Busy_Vec(Busy_Vec)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit iv, input logic [4:0] ird,
                               input bit av, input logic [4:0] ard, input logic [31:0] adat,
                               input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge Clk);
    Reset = rst; Iss_Valid = iv; Iss_Rd = ird;
    Alu_Valid = av; Alu_Rd = ard; Alu_Data = adat;
    Lsu_Valid = lv; Lsu_Rd = lrd; Lsu_Data = ldat;
    Rs1_Addr = r1; Rs2_Addr = r2;
    #3;
  endtask

  task automatic idle(input logic [4:0] r1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  // Compare process: each cycle derive expected outputs from the model, then
  // advance the model at the following clock edge.
  always begin : compare
    bit          g_alu, g_lsu, hit1, hit2;
    logic [31:0] n_busy, n_data, e_rs1d, e_rs2d;
    logic [4:0]  n_addr;
    bit          e_stall, e_b1, e_b2, n_ptr;
    @(negedge Clk);
    #2;
    g_alu = 0; g_lsu = 0; e_stall = 0; e_b1 = 0; e_b2 = 0;
    e_rs1d = '0; e_rs2d = '0;
    if (!Reset) begin
      if (Alu_Valid && Lsu_Valid) begin
        g_alu = m_ptr_alu;
        g_lsu = !m_ptr_alu;
      end else begin
        g_alu = Alu_Valid;
        g_lsu = Lsu_Valid;
      end
      e_stall = Iss_Valid && m_busy[Iss_Rd];
      hit1 = BYP && (Rs1_Addr == m_rd_addr) && (m_rd_addr != 0);
      hit2 = BYP && (Rs2_Addr == m_rd_addr) && (m_rd_addr != 0);
      e_b1 = m_busy[Rs1_Addr] && (Rs1_Addr != 0) && !hit1;
      e_b2 = m_busy[Rs2_Addr] && (Rs2_Addr != 0) && !hit2;
      e_rs1d = hit1 ? m_rd_data : rf[Rs1_Addr];
      e_rs2d = hit2 ? m_rd_data : rf[Rs2_Addr];
    end
    checkOutput("Alu_Ready", {31'b0, Alu_Ready}, {31'b0, g_alu});
    checkOutput("Lsu_Ready", {31'b0, Lsu_Ready}, {31'b0, g_lsu});
    checkOutput("Iss_Stall", {31'b0, Iss_Stall}, {31'b0, e_stall});
    checkOutput("Rs1_Busy", {31'b0, Rs1_Busy}, {31'b0, e_b1});
    checkOutput("Rs2_Busy", {31'b0, Rs2_Busy}, {31'b0, e_b2});
    checkOutput("Rs1_Data", Rs1_Data, e_rs1d);
    checkOutput("Rs2_Data", Rs2_Data, e_rs2d);
    checkOutput("Rd_Addr", {27'b0, Rd_Addr}, {27'b0, m_rd_addr});
    checkOutput("Rd_Data", Rd_Data, m_rd_data);
    checkOutput("Busy_Vec", Busy_Vec, m_busy);

    if (Reset) begin
      n_busy = '0; n_addr = '0; n_data = '0; n_ptr = 1'b0;
    end else begin
      n_busy = m_busy;
      if (m_rd_addr != 0) n_busy[m_rd_addr] = 1'b0;
      if (Iss_Valid && !e_stall && Iss_Rd != 0) n_busy[Iss_Rd] = 1'b1;
      n_ptr = (Alu_Valid && Lsu_Valid) ? !m_ptr_alu : m_ptr_alu;
      if (g_alu) begin
        n_addr = Alu_Rd; n_data = Alu_Data;
      end else if (g_lsu) begin
        n_addr = Lsu_Rd; n_data = Lsu_Data;
      end else begin
        n_addr = '0; n_data = m_rd_data;
      end
    end
    @(posedge Clk);
    if (!Reset && m_rd_addr != 0) rf[m_rd_addr] = m_rd_data;
    m_busy = n_busy; m_rd_addr = n_addr; m_rd_data = n_data; m_ptr_alu = n_ptr;
    alu_done = g_alu; lsu_done = g_lsu;
  end

  initial begin : stimulus
    bit exp_lsu [4];
    bit          av, lv, iv, rst;
    logic [4:0]  ard, lrd, ird;
    logic [31:0] adat, ldat;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    Reset = 1; Iss_Valid = 0; Iss_Rd = 0; Alu_Valid = 0; Alu_Rd = 0; Alu_Data = 0;
    Lsu_Valid = 0; Lsu_Rd = 0; Lsu_Data = 0; Rs1_Addr = 0; Rs2_Addr = 0;

    // Reset, dispatch x5, ALU write-back to x5 and read it back.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset Rd_Addr", {27'b0, Rd_Addr}, 32'd0);
    checkOutput("reset Busy_Vec", Busy_Vec, 32'd0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dispatch5 Iss_Stall", {31'b0, Iss_Stall}, 32'd0);
    idle(5);
    checkOutput("dispatch5 Busy_Vec", Busy_Vec, 32'h20);
    checkOutput("dispatch5 Rs1_Busy", {31'b0, Rs1_Busy}, 32'd1);
    applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    checkOutput("wb5 Alu_Ready", {31'b0, Alu_Ready}, 32'd1);
    idle(5);
    checkOutput("wb5 Rd_Addr", {27'b0, Rd_Addr}, 32'd5);
    checkOutput("wb5 Rd_Data", Rd_Data, 32'hDEADBEEF);
    checkOutput("wb5 N+1 Rs1_Busy", {31'b0, Rs1_Busy}, BYP ? 32'd0 : 32'd1);
    checkOutput("wb5 N+1 Rs1_Data", Rs1_Data, BYP ? 32'hDEADBEEF : 32'd0);
    idle(5);
    checkOutput("wb5 N+2 Busy_Vec", Busy_Vec, 32'd0);
    checkOutput("wb5 N+2 Rd_Addr", {27'b0, Rd_Addr}, 32'd0);
    checkOutput("wb5 N+2 Rs1_Data", Rs1_Data, 32'hDEADBEEF);
    checkOutput("wb5 N+2 Rs1_Busy", {31'b0, Rs1_Busy}, 32'd0);

    // Continuous contention right after reset alternates, LSU first.
    exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'h100 + i, 1, 2, 32'h200 + i, 0, 0);
      checkOutput("contend Lsu_Ready", {31'b0, Lsu_Ready}, {31'b0, exp_lsu[i]});
      checkOutput("contend Alu_Ready", {31'b0, Alu_Ready}, {31'b0, !exp_lsu[i]});
      if (i > 0)
        checkOutput("contend Rd_Addr", {27'b0, Rd_Addr}, exp_lsu[i-1] ? 32'd2 : 32'd1);
    end
    idle(0);
    checkOutput("contend last Rd_Addr", {27'b0, Rd_Addr}, 32'd1);
    checkOutput("contend last Rd_Data", Rd_Data, 32'h103);

    // WAW stall, then same-edge clear and set of x7.
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw Iss_Stall", {31'b0, Iss_Stall}, 32'd1);
    checkOutput("waw Busy_Vec", Busy_Vec, 32'h80);
    idle(0);
    checkOutput("waw hold Busy_Vec", Busy_Vec, 32'h80);
    applyStimulus(0, 0, 0, 1, 7, 32'd77, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    checkOutput("x7 cleared Busy_Vec", Busy_Vec, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 32'd55, 0, 0);
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("setwins Rd_Addr", {27'b0, Rd_Addr}, 32'd7);
    checkOutput("setwins Iss_Stall", {31'b0, Iss_Stall}, 32'd0);
    idle(0);
    checkOutput("setwins Busy_Vec", Busy_Vec, 32'h80);
    applyStimulus(0, 0, 0, 1, 7, 32'd1, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

    // x0 handling.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0 Iss_Stall", {31'b0, Iss_Stall}, 32'd0);
    checkOutput("x0 Rs1_Busy", {31'b0, Rs1_Busy}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'd123, 0, 0);
    checkOutput("x0 Busy_Vec", Busy_Vec, 32'd0);
    checkOutput("x0 Lsu_Ready", {31'b0, Lsu_Ready}, 32'd1);
    idle(0);
    checkOutput("x0 Rd_Addr", {27'b0, Rd_Addr}, 32'd0);

    // Reset in the middle of activity.
    for (int r = 8; r < 12; r++) applyStimulus(0, 1, r[4:0], 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 3, 32'd9, 0, 0, 0, 0, 0);
    checkOutput("midrst Busy_Vec before", Busy_Vec, 32'h0000_0F00);
    checkOutput("midrst Alu_Ready", {31'b0, Alu_Ready}, 32'd0);
    applyStimulus(0, 0, 0, 1, 3, 32'd9, 1, 4, 32'd10, 0, 0);
    checkOutput("midrst Busy_Vec after", Busy_Vec, 32'd0);
    checkOutput("midrst Rd_Addr", {27'b0, Rd_Addr}, 32'd0);
    checkOutput("midrst first grant LSU", {31'b0, Lsu_Ready}, 32'd1);
    idle(0);
    idle(0);

    // Randomized traffic; requesters hold payload until transferred.
    for (int c = 0; c < 3000; c++) begin
      @(posedge Clk);
      #1;
      rst = ($urandom_range(0, 99) < 2);
      if (!(Alu_Valid && !alu_done)) begin
        av = ($urandom_range(0, 99) < 60);
        ard = 5'($urandom_range(0, 9));
        adat = $urandom;
      end else begin
        av = 1; ard = Alu_Rd; adat = Alu_Data;
      end
      if (!(Lsu_Valid && !lsu_done)) begin
        lv = ($urandom_range(0, 99) < 60);
        lrd = 5'($urandom_range(0, 9));
        ldat = $urandom;
      end else begin
        lv = 1; lrd = Lsu_Rd; ldat = Lsu_Data;
      end
      iv = ($urandom_range(0, 99) < 50);
      ird = 5'($urandom_range(0, 9));
      applyStimulus(rst, iv, ird, av, ard, adat, lv, lrd, ldat,
                    5'($urandom_range(0, 10)), 5'($urandom_range(0, 31)));
    end

    @(negedge Clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
